// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - bit-serial weight / activation feeder for an N-row systolic array
//
// Purpose:
//   Holds an N x K_MAX buffer of {weight, activation} pairs and streams it into
//   a systolic array. For every reduction index k the weight is sent one bit per
//   cycle (LSB first, P bits) while the matching activation is held on the row
//   for those P cycles. Row r lags row 0 by r cycles (diagonal skew).
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   begin a streaming pass (accepted only when idle)
//   precision  in   weight bits per element, sampled on accepted start
//   k_len      in   reduction length K, sampled on accepted start
//   wr_en      in   buffer write strobe (ignored while busy)
//   wr_row     in   buffer row written
//   wr_idx     in   buffer k index written
//   wr_weight  in   weight word
//   wr_act     in   activation word
//   busy       out  high from accepted start until done
//   weight_out out  one serial weight bit per row
//   act_out    out  activation per row, row r at [r*ACT_WIDTH +: ACT_WIDTH]
//   valid_out  out  per-row beat valid
//   sys_start  out  one-cycle start pulse to the array
//   done       out  one-cycle end-of-pass pulse

module systolic_feeder #(
  parameter int ACT_WIDTH = 16,
  parameter int N         = 2,
  parameter int K_MAX     = 8,
  parameter int W_MAX     = 8,
  localparam int RW       = (N > 1) ? $clog2(N) : 1,
  localparam int KW       = (K_MAX > 1) ? $clog2(K_MAX) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [3:0]             precision,
  input  logic [3:0]             k_len,
  input  logic                   wr_en,
  input  logic [RW-1:0]          wr_row,
  input  logic [KW-1:0]          wr_idx,
  input  logic [W_MAX-1:0]       wr_weight,
  input  logic [ACT_WIDTH-1:0]   wr_act,
  output logic                   busy,
  output logic [N-1:0]           weight_out,
  output logic [N*ACT_WIDTH-1:0] act_out,
  output logic [N-1:0]           valid_out,
  output logic                   sys_start,
  output logic                   done
);

  localparam int BW = (W_MAX > 1) ? $clog2(W_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t r_state;
  logic   r_busy;
  logic   r_sys_start;
  logic   r_done;

  // Pass parameters latched on accepted start.
  logic [3:0] r_p;
  logic [3:0] r_kk;

  // Row-0 beat position (k outer, b inner).
  logic [3:0] r_k_cnt;
  logic [3:0] r_b_cnt;

  // Skew pipeline: stage r holds the beat row r is driving this cycle.
  logic          r_vld [N];
  logic [KW-1:0] r_k   [N];
  logic [BW-1:0] r_b   [N];

  // Operand buffer.
  logic [W_MAX-1:0]     r_wbuf [N][K_MAX];
  logic [ACT_WIDTH-1:0] r_abuf [N][K_MAX];

  logic [3:0] w_p_eff;
  logic [3:0] w_k_eff;
  logic       w_b_wrap;
  logic       w_row0_last;
  logic       w_tail_last;
  logic [3:0] w_nb;
  logic [3:0] w_nk;
  logic       w_wr_ok;

  // Precision 0 is treated as 1 bit; anything above W_MAX saturates.
  assign w_p_eff = (precision == 4'd0) ? 4'd1 :
                   ((32'(precision) > W_MAX) ? 4'(W_MAX) : precision);
  assign w_k_eff = (32'(k_len) > K_MAX) ? 4'(K_MAX) : k_len;

  assign w_b_wrap    = (r_b_cnt == r_p - 4'd1);
  assign w_row0_last = w_b_wrap && (r_k_cnt == r_kk - 4'd1);
  assign w_nb        = w_b_wrap ? 4'd0 : r_b_cnt + 4'd1;
  assign w_nk        = w_b_wrap ? r_k_cnt + 4'd1 : r_k_cnt;

  // The last row is on its final beat; done follows on the next cycle.
  assign w_tail_last = r_vld[N-1] &&
                       (4'(r_k[N-1]) == r_kk - 4'd1) &&
                       (4'(r_b[N-1]) == r_p - 4'd1);

  assign w_wr_ok = (32'(wr_row) < N) && (32'(wr_idx) < K_MAX);

  // Control FSM and skew pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_sys_start <= 1'b0;
      r_done      <= 1'b0;
      r_p         <= 4'd0;
      r_kk        <= 4'd0;
      r_k_cnt     <= 4'd0;
      r_b_cnt     <= 4'd0;
      for (int r = 0; r < N; r++) begin
        r_vld[r] <= 1'b0;
        r_k[r]   <= '0;
        r_b[r]   <= '0;
      end
    end else begin
      r_sys_start <= 1'b0;
      r_done      <= 1'b0;

      // Each row inherits the beat the row above drove one cycle earlier.
      for (int r = N - 1; r > 0; r--) begin
        r_vld[r] <= r_vld[r-1];
        r_k[r]   <= r_k[r-1];
        r_b[r]   <= r_b[r-1];
      end
      r_vld[0] <= 1'b0;
      r_k[0]   <= '0;
      r_b[0]   <= '0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_p  <= w_p_eff;
            r_kk <= w_k_eff;
            if (w_k_eff == 4'd0) begin
              // Empty pass: no beats, just acknowledge.
              r_done <= 1'b1;
            end else begin
              r_state     <= S_STREAM;
              r_busy      <= 1'b1;
              r_sys_start <= 1'b1;
              r_vld[0]    <= 1'b1;
              r_k_cnt     <= 4'd0;
              r_b_cnt     <= 4'd0;
            end
          end
        end

        S_STREAM: begin
          if (w_row0_last) begin
            if (N == 1) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_DRAIN;
            end
          end else begin
            r_vld[0] <= 1'b1;
            r_k[0]   <= KW'(w_nk);
            r_b[0]   <= BW'(w_nb);
            r_k_cnt  <= w_nk;
            r_b_cnt  <= w_nb;
          end
        end

        S_DRAIN: begin
          if (w_tail_last) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Operand buffer; frozen while a pass is running so reads stay stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        for (int k = 0; k < K_MAX; k++) begin
          r_wbuf[r][k] <= '0;
          r_abuf[r][k] <= '0;
        end
      end
    end else if (wr_en && !r_busy && w_wr_ok) begin
      r_wbuf[wr_row][wr_idx] <= wr_weight;
      r_abuf[wr_row][wr_idx] <= wr_act;
    end
  end

  // Row outputs are a pure function of the stage registers and the frozen
  // buffer, so they drop to zero as soon as reset clears the stages.
  always_comb begin
    weight_out = '0;
    act_out    = '0;
    valid_out  = '0;
    for (int r = 0; r < N; r++) begin
      if (r_vld[r]) begin
        valid_out[r]                         = 1'b1;
        weight_out[r]                        = r_wbuf[r][r_k[r]][r_b[r]];
        act_out[r*ACT_WIDTH +: ACT_WIDTH]    = r_abuf[r][r_k[r]];
      end
    end
  end

  assign busy      = r_busy;
  assign sys_start = r_sys_start;
  assign done      = r_done;

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - directed self-checking bench for systolic_feeder

module tb_systolic_feeder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  precision;
  logic [3:0]  k_len;
  logic        wr_en;
  logic [0:0]  wr_row;
  logic [2:0]  wr_idx;
  logic [7:0]  wr_weight;
  logic [15:0] wr_act;
  logic        busy;
  logic [1:0]  weight_out;
  logic [31:0] act_out;
  logic [1:0]  valid_out;
  logic        sys_start;
  logic        done;

  int checks = 0;
  int errors = 0;

  // Bench-side copy of what the buffer should hold.
  logic [7:0]  m_w [2][8];
  logic [15:0] m_a [2][8];

  // Hand-derived row weight sequences for weights {5,A} and {3,C}, P=4.
  logic [7:0] lit0;
  logic [7:0] lit1;

  systolic_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .precision  (precision),
    .k_len      (k_len),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_idx     (wr_idx),
    .wr_weight  (wr_weight),
    .wr_act     (wr_act),
    .busy       (busy),
    .weight_out (weight_out),
    .act_out    (act_out),
    .valid_out  (valid_out),
    .sys_start  (sys_start),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int cyc, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s c=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic wr(input int row, input int idx, input logic [7:0] w, input logic [15:0] a);
    wr_en     = 1'b1;
    wr_row    = 1'(row);
    wr_idx    = 3'(idx);
    wr_weight = w;
    wr_act    = a;
    tick;
    wr_en     = 1'b0;
    m_w[row][idx] = w;
    m_a[row][idx] = a;
  endtask

  task automatic clear_model;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 8; k++) begin
        m_w[r][k] = 8'h00;
        m_a[r][k] = 16'h0000;
      end
  endtask

  // Caller has raised start with precision/k_len set. Ends in the done cycle.
  task automatic run_pass(input int p, input int kk, input bit interfere, input bit hold, input bit lit);
    int         last;
    int         j;
    logic [1:0] ev;
    logic [1:0] ew;
    logic [31:0] ea;
    tick;
    if (!hold) start = 1'b0;
    last = kk * p + 1;
    for (int c = 0; c <= last; c++) begin
      ev = 2'b00;
      ew = 2'b00;
      ea = 32'h0;
      for (int r = 0; r < 2; r++) begin
        if (c >= r && (c - r) < kk * p) begin
          j = c - r;
          ev[r] = 1'b1;
          ew[r] = m_w[r][j / p][j % p];
          ea[r*16 +: 16] = m_a[r][j / p];
        end
      end
      chk("sys_start", c, 64'(sys_start), 64'(c == 0));
      chk("busy",      c, 64'(busy),      64'(c < last));
      chk("done",      c, 64'(done),      64'(c == last));
      chk("valid_out", c, 64'(valid_out), 64'(ev));
      chk("weight_out",c, 64'(weight_out),64'(ew));
      chk("act_out",   c, 64'(act_out),   64'(ea));
      if (lit) begin
        if (c < 8) chk("lit_row0", c, 64'(weight_out[0]), 64'(lit0[c]));
        if (c >= 1 && c <= 8) chk("lit_row1", c, 64'(weight_out[1]), 64'(lit1[c-1]));
      end
      if (interfere && c == 3) begin
        start     = 1'b1;
        precision = 4'd1;
        k_len     = 4'd1;
        wr_en     = 1'b1;
        wr_row    = 1'b0;
        wr_idx    = 3'd0;
        wr_weight = 8'hFF;
        wr_act    = 16'hDEAD;
      end
      if (interfere && c == 4) begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      if (c < last) tick;
    end
  endtask

  initial begin
    lit0      = 8'b1010_0101;
    lit1      = 8'b1100_0011;
    rst       = 1'b1;
    start     = 1'b0;
    precision = 4'd0;
    k_len     = 4'd0;
    wr_en     = 1'b0;
    wr_row    = 1'b0;
    wr_idx    = 3'd0;
    wr_weight = 8'h00;
    wr_act    = 16'h0000;
    clear_model();
    tick;
    tick;
    chk("rst_busy",      0, 64'(busy),       64'd0);
    chk("rst_valid",     0, 64'(valid_out),  64'd0);
    chk("rst_weight",    0, 64'(weight_out), 64'd0);
    chk("rst_act",       0, 64'(act_out),    64'd0);
    chk("rst_sys_start", 0, 64'(sys_start),  64'd0);
    chk("rst_done",      0, 64'(done),       64'd0);
    rst = 1'b0;
    tick;

    wr(0, 0, 8'h05, 16'h1111);
    wr(0, 1, 8'h0A, 16'h2222);
    wr(0, 2, 8'h81, 16'h5555);
    wr(1, 0, 8'h03, 16'h3333);
    wr(1, 1, 8'h0C, 16'h4444);
    wr(1, 2, 8'h80, 16'h6666);

    // Basic pass P=4, K=2, checked against the hand sequences too.
    precision = 4'd4; k_len = 4'd2; start = 1'b1;
    run_pass(4, 2, 1'b0, 1'b0, 1'b1);

    // Same pass with start and a buffer write injected mid-stream.
    precision = 4'd4; k_len = 4'd2; start = 1'b1;
    run_pass(4, 2, 1'b1, 1'b0, 1'b1);
    tick;
    chk("post_done", 0, 64'(done), 64'd0);
    chk("post_busy", 0, 64'(busy), 64'd0);

    // The injected write must not have landed.
    precision = 4'd4; k_len = 4'd2; start = 1'b1;
    run_pass(4, 2, 1'b0, 1'b0, 1'b1);

    // precision 0 -> 1 bit, K=3.
    precision = 4'd0; k_len = 4'd3; start = 1'b1;
    run_pass(1, 3, 1'b0, 1'b0, 1'b0);

    // precision 12 saturates to 8, K=1.
    precision = 4'd12; k_len = 4'd1; start = 1'b1;
    run_pass(8, 1, 1'b0, 1'b0, 1'b0);

    // k_len 12 saturates to K_MAX=8.
    precision = 4'd1; k_len = 4'd12; start = 1'b1;
    run_pass(1, 8, 1'b0, 1'b0, 1'b0);

    // K=0: done one cycle after start, nothing else.
    precision = 4'd4; k_len = 4'd0; start = 1'b1;
    tick;
    start = 1'b0;
    chk("k0_done",      0, 64'(done),      64'd1);
    chk("k0_sys_start", 0, 64'(sys_start), 64'd0);
    chk("k0_busy",      0, 64'(busy),      64'd0);
    chk("k0_valid",     0, 64'(valid_out), 64'd0);
    tick;
    chk("k0_done_end",  1, 64'(done),      64'd0);
    chk("k0_valid_end", 1, 64'(valid_out), 64'd0);

    // start held through done: next pass starts the cycle after done.
    precision = 4'd4; k_len = 4'd2; start = 1'b1;
    run_pass(4, 2, 1'b0, 1'b1, 1'b0);
    tick;
    start = 1'b0;
    chk("held_sys_start", 10, 64'(sys_start), 64'd1);
    chk("held_busy",      10, 64'(busy),      64'd1);
    tick;
    tick;
    tick;
    chk("pre_rst_valid", 13, 64'(valid_out), 64'd3);

    // Asynchronous reset mid-stream, away from any clock edge.
    rst = 1'b1;
    #2;
    chk("arst_valid",     0, 64'(valid_out),  64'd0);
    chk("arst_weight",    0, 64'(weight_out), 64'd0);
    chk("arst_act",       0, 64'(act_out),    64'd0);
    chk("arst_busy",      0, 64'(busy),       64'd0);
    chk("arst_sys_start", 0, 64'(sys_start),  64'd0);
    chk("arst_done",      0, 64'(done),       64'd0);
    clear_model();
    tick;
    rst = 1'b0;
    tick;

    // Buffer was cleared: beats still run, carrying zeros.
    precision = 4'd4; k_len = 4'd2; start = 1'b1;
    run_pass(4, 2, 1'b0, 1'b0, 1'b0);

    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
